// File: rtl/cpu_gpr_mp_pkg.sv
// Shared types and constants for the multi-port GPR file.
// Clear FSM encodings and default geometry live here.
package cpu_gpr_mp_pkg;

  localparam int GPR_DATA_W = 32;
  localparam int GPR_ADDR_W = 5;

  localparam logic ENABLE_N  = 1'b0;
  localparam logic DISABLE_N = 1'b1;

  typedef enum logic {
    GPR_ST_IDLE  = 1'b0,
    GPR_ST_CLEAR = 1'b1
  } gpr_state_e;

endpackage

// File: rtl/cpu_gpr_mp_clr_ctrl.sv
// Sequential clear engine: walks the array one entry per cycle.
// Owns the IDLE/CLEAR FSM, the entry counter and busy.
module cpu_gpr_clr_ctrl
  import cpu_gpr_mp_pkg::*;
#(
  parameter int ADDR_W = GPR_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_block,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  gpr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      GPR_ST_IDLE: begin
        if (clr_req) begin
          state_d   = GPR_ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      GPR_ST_CLEAR: begin
        if (clr_cnt_q == '1) begin
          state_d   = GPR_ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = GPR_ST_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= GPR_ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign busy     = (state_q == GPR_ST_CLEAR);
  assign clr_we   = busy & ~reset;
  assign clr_addr = clr_cnt_q;

  // A clear request in IDLE also swallows that cycle's writes.
  assign wr_block = reset | busy | clr_req;

endmodule

// File: rtl/cpu_gpr_mp.sv
// Parametrised GPR file: RD_PORTS combinational reads, two writes,
// same-cycle bypass and a RAM-friendly sequential clear.
module cpu_gpr_mp
  import cpu_gpr_mp_pkg::*;
#(
  parameter int DATA_W   = GPR_DATA_W,
  parameter int ADDR_W   = GPR_ADDR_W,
  parameter int RD_PORTS = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
  output logic [RD_PORTS*DATA_W-1:0] rd_data,
  input  logic                       we0_n,
  input  logic [ADDR_W-1:0]          wr_addr0,
  input  logic [DATA_W-1:0]          wr_data0,
  input  logic                       we1_n,
  input  logic [ADDR_W-1:0]          wr_addr1,
  input  logic [DATA_W-1:0]          wr_data1,
  input  logic                       clr_req,
  output logic                       busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic ZR  = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_block;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic w0_en, w1_en, w0_keep;

  cpu_gpr_clr_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clr (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .busy     (busy),
    .wr_block (wr_block),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  always_comb begin
    w0_en = (we0_n == ENABLE_N) & ~wr_block;
    w1_en = (we1_n == ENABLE_N) & ~wr_block;
    if (ZR && wr_addr0 == '0) w0_en = 1'b0;
    if (ZR && wr_addr1 == '0) w1_en = 1'b0;
    w0_keep = w0_en & ~(w1_en & (wr_addr0 == wr_addr1));
  end

  // No reset on the array so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else begin
      if (w0_keep) mem_q[wr_addr0] <= wr_data0;
      if (w1_en)   mem_q[wr_addr1] <= wr_data1;
    end
  end

  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] lane;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      lane = mem_q[ra];
      if (busy) begin
        lane = '0;
      end else if (ZR && ra == '0) begin
        lane = '0;
      end else if (w1_en && wr_addr1 == ra) begin
        lane = wr_data1;
      end else if (w0_en && wr_addr0 == ra) begin
        lane = wr_data0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = lane;
  end

endmodule

// File: tb/tb_cpu_gpr_mp.sv
// Scoreboard bench for cpu_gpr_mp; two instances share stimulus,
// one with ZERO_REG=0 (a) and one with ZERO_REG=1 (b).
module tb_cpu_gpr_mp;
  import cpu_gpr_mp_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NP    = 2;
  localparam int DEPTH = 32;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NP*AW-1:0] rd_addr;
  logic [NP*DW-1:0] rd_data_a, rd_data_b;
  logic           we0_n, we1_n;
  logic [AW-1:0]  wr_addr0, wr_addr1;
  logic [DW-1:0]  wr_data0, wr_data1;
  logic           clr_req;
  logic           busy_a, busy_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          dut;
    int          lane;
    logic [DW-1:0] val;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  cpu_gpr_mp #(
    .DATA_W(DW), .ADDR_W(AW), .RD_PORTS(NP), .ZERO_REG(0)
  ) u_a (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data_a),
    .we0_n(we0_n), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .we1_n(we1_n), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .clr_req(clr_req), .busy(busy_a)
  );

  cpu_gpr_mp #(
    .DATA_W(DW), .ADDR_W(AW), .RD_PORTS(NP), .ZERO_REG(1)
  ) u_b (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data_b),
    .we0_n(we0_n), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .we1_n(we1_n), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .clr_req(clr_req), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    we0_n   = DISABLE_N;
    we1_n   = DISABLE_N;
    clr_req = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {a1[AW-1:0], a0[AW-1:0]};
  endtask

  task automatic push(input int dut, input int lane,
                      input logic [DW-1:0] val);
    exp_t e;
    e.dut  = dut;
    e.lane = lane;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic push_all(input logic [DW-1:0] v0,
                          input logic [DW-1:0] v1);
    push(0, 0, v0);
    push(0, 1, v1);
    push(1, 0, v0);
    push(1, 1, v1);
  endtask

  task automatic drain(input string tag);
    exp_t          e;
    logic [DW-1:0] got;
    #2;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = (e.dut == 1) ? rd_data_b[e.lane*DW +: DW]
                         : rd_data_a[e.lane*DW +: DW];
      chk($sformatf("%s d%0d l%0d", tag, e.dut, e.lane),
          {32'h0, got}, {32'h0, e.val});
    end
  endtask

  // Counts busy cycles while hammering both write ports.
  task automatic run_clear(input string tag, input int expn,
                           input int pulse_at, input int reset_at);
    int n = 0;
    while (busy_a && n < 200) begin
      clr_req  = (n == pulse_at);
      reset    = (n == reset_at);
      we0_n    = ENABLE_N;
      wr_addr0 = 5'd3;
      wr_data0 = 32'h77;
      we1_n    = ENABLE_N;
      wr_addr1 = 5'd20;
      wr_data1 = 32'h99;
      set_rd(3, 20);
      push_all('0, '0);
      drain({tag, "_rd"});
      chk({tag, "_busy_b"}, {63'h0, busy_b}, 64'h1);
      step();
      n++;
    end
    reset = 1'b0;
    idle_in();
    chk({tag, "_len"}, n, expn);
    chk({tag, "_end_b"}, {63'h0, busy_b}, 64'h0);
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      set_rd(i, DEPTH - 1 - i);
      push_all('0, '0);
      drain(tag);
      step();
    end
  endtask

  initial begin
    idle_in();
    rd_addr  = '0;
    wr_addr0 = '0;
    wr_addr1 = '0;
    wr_data0 = '0;
    wr_data1 = '0;
    reset    = 1'b1;
    repeat (3) step();
    chk("rst_busy", {63'h0, busy_a}, 64'h1);
    set_rd(4, 9);
    push_all('0, '0);
    drain("rst_rd");

    run_clear("boot", DEPTH, -1, -1);
    sweep_zero("boot_sweep");

    // bypass then array read
    we0_n = ENABLE_N; wr_addr0 = 5'd5; wr_data0 = 32'hDEADBEEF;
    set_rd(5, 6);
    push_all(32'hDEADBEEF, '0);
    drain("byp5");
    step();
    idle_in();
    push_all(32'hDEADBEEF, '0);
    drain("arr5");

    // same address: port 1 wins
    we0_n = ENABLE_N; wr_addr0 = 5'd7; wr_data0 = 32'h11;
    we1_n = ENABLE_N; wr_addr1 = 5'd7; wr_data1 = 32'h22;
    set_rd(7, 5);
    push_all(32'h22, 32'hDEADBEEF);
    drain("byp7");
    step();
    idle_in();
    push_all(32'h22, 32'hDEADBEEF);
    drain("arr7");

    // different addresses in one cycle, then fill 1..4
    for (int i = 1; i <= 4; i += 2) begin
      we0_n = ENABLE_N; wr_addr0 = i[AW-1:0];     wr_data0 = 32'h100 + i;
      we1_n = ENABLE_N; wr_addr1 = i[AW-1:0] + 1; wr_data1 = 32'h101 + i;
      set_rd(i, i + 1);
      push_all(32'h100 + i, 32'h101 + i);
      drain("fill_byp");
      step();
    end
    idle_in();
    for (int i = 1; i <= 4; i++) begin
      set_rd(i, 7);
      push_all(32'h100 + i, 32'h22);
      drain("fill_arr");
      step();
    end

    // ZERO_REG behaviour on address 0
    we0_n = ENABLE_N; wr_addr0 = '0; wr_data0 = 32'hFFFF;
    set_rd(0, 0);
    push(0, 0, 32'hFFFF);
    push(1, 0, '0);
    push(1, 1, '0);
    drain("zr_byp");
    step();
    idle_in();
    push(0, 1, 32'hFFFF);
    push(1, 0, '0);
    drain("zr_arr");

    // clear request drops the coincident write
    clr_req = 1'b1;
    we0_n = ENABLE_N; wr_addr0 = 5'd9; wr_data0 = 32'h55;
    step();
    idle_in();
    chk("clr_rise", {63'h0, busy_a}, 64'h1);
    run_clear("clrq", DEPTH, 10, -1);
    for (int i = 1; i <= 9; i++) begin
      set_rd(i, 20);
      push_all('0, '0);
      drain("clrq_arr");
      step();
    end

    // reset in the middle of a clear restarts it
    we0_n = ENABLE_N; wr_addr0 = 5'd25; wr_data0 = 32'hAB;
    we1_n = ENABLE_N; wr_addr1 = 5'd2;  wr_data1 = 32'hCD;
    step();
    idle_in();
    set_rd(25, 2);
    push_all(32'hAB, 32'hCD);
    drain("pre_rst");
    clr_req = 1'b1;
    step();
    idle_in();
    run_clear("midrst", 12 + 1 + DEPTH, -1, 12);
    sweep_zero("midrst_sweep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
